// File: rtl/apb_mem_pkg.sv
// Shared definitions for the APB4 wait-state memory slave: transfer FSM
// states, PSLVERR response codes and width helpers derived from DATAW.
package apb_mem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic OKAY  = 1'b0;
    localparam logic ERROR = 1'b1;

    // Number of byte lanes (PSTRB width) for a given data width.
    function automatic int strb_width(input int dataw);
        return dataw / 8;
    endfunction

    // Number of low address bits that select a byte inside a word.
    function automatic int byte_off_bits(input int dataw);
        return $clog2(dataw / 8);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATAW word storage. Cleared by the asynchronous reset, written
// through a byte-strobe port, read combinationally (the caller registers
// the read data).
module apb_mem_array
    import apb_mem_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int DEPTH = 256,
    localparam int STRBW = strb_width(DATAW),
    localparam int IDXW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDXW-1:0]  waddr,
    input  logic [STRBW-1:0] wstrb,
    input  logic [DATAW-1:0] wdata,
    input  logic [IDXW-1:0]  raddr,
    output logic [DATAW-1:0] rdata
);

    logic [DATAW-1:0] mem_r [DEPTH];

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [DATAW-1:0] merge_bytes(
        input logic [DATAW-1:0] old_word,
        input logic [DATAW-1:0] new_word,
        input logic [STRBW-1:0] strb
    );
        logic [DATAW-1:0] res;
        res = old_word;
        for (int b = 0; b < STRBW; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Storage: clear every word on reset, merge strobed bytes on write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATAW{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= merge_bytes(mem_r[waddr], wdata, wstrb);
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB4 memory slave with byte strobes, programmable wait states and an
// error response for misaligned, below-window or out-of-range addresses.
// Optional feature: define APB_MEM_WRITE_PROTECT_EN to make words with
// index < WP_WORDS read-only (writes there complete with PSLVERR=1).
module apb_mem_slave_ws
    import apb_mem_pkg::*;
#(
    parameter int               ADDRW       = 32,
    parameter int               DATAW       = 32,
    parameter int               DEPTH       = 256,
    parameter logic [ADDRW-1:0] BASE_ADDR   = '0,
    parameter int               WAIT_CYCLES = 1,
    parameter int               WP_WORDS    = 16,
    localparam int              STRBW       = strb_width(DATAW)
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [ADDRW-1:0] PADDR,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [DATAW-1:0] PWDATA,
    input  logic [STRBW-1:0] PSTRB,
    output logic             PREADY,
    output logic [DATAW-1:0] PRDATA,
    output logic             PSLVERR
);

    localparam int         OFFB      = byte_off_bits(DATAW);
    localparam int         IDXW      = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

`ifdef APB_MEM_WRITE_PROTECT_EN
    localparam logic WP_EN = 1'b1;
`else
    localparam logic WP_EN = 1'b0;
`endif

    state_t           state_r, state_s;
    logic [3:0]       cnt_r, cnt_s;
    logic [IDXW-1:0]  idx_r;
    logic             err_r;
    logic             write_r;
    logic [DATAW-1:0] wdata_r;
    logic [STRBW-1:0] strb_r;
    logic [DATAW-1:0] prdata_r;

    logic [ADDRW-1:0] offset_s;
    logic [ADDRW-1:0] word_s;
    logic [IDXW-1:0]  idx_s;
    logic             err_s;
    logic             ready_s;
    logic             latch_s;
    logic             mem_we_s;
    logic [DATAW-1:0] mem_rdata_s;

    // Address decode of the current PADDR into word index and error flag.
    always_comb begin
        offset_s = PADDR - BASE_ADDR;
        word_s   = offset_s >> OFFB;
        idx_s    = word_s[IDXW-1:0];
        err_s    = (PADDR < BASE_ADDR)
                 | (word_s >= ADDRW'(DEPTH))
                 | ((PADDR & ADDRW'(STRBW - 1)) != {ADDRW{1'b0}})
                 | (WP_EN & PWRITE & (word_s < ADDRW'(WP_WORDS)));
    end

    assign ready_s = (state_r == ACCESS) && (cnt_r == 4'd0);

    // Transfer FSM: next state, wait counter and memory write enable.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        latch_s  = 1'b0;
        mem_we_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    latch_s = 1'b1;
                    cnt_s   = WAIT_INIT;
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    // Master abandoned the transfer: drop it without a write.
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end else if (PENABLE) begin
                    if (cnt_r == 4'd0) begin
                        state_s  = IDLE;
                        mem_we_s = write_r && !err_r;
                    end else begin
                        cnt_s = cnt_r - 4'd1;
                    end
                end else begin
                    state_s = ACCESS;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Capture the transfer attributes during the setup phase.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_r   <= {IDXW{1'b0}};
            err_r   <= 1'b0;
            write_r <= 1'b0;
            wdata_r <= {DATAW{1'b0}};
            strb_r  <= {STRBW{1'b0}};
        end else if (latch_s) begin
            idx_r   <= idx_s;
            err_r   <= err_s;
            write_r <= PWRITE;
            wdata_r <= PWDATA;
            strb_r  <= PSTRB;
        end
    end

    // Read data is fetched at setup and held until the next read transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prdata_r <= {DATAW{1'b0}};
        end else if (latch_s && !PWRITE) begin
            prdata_r <= err_s ? {DATAW{1'b0}} : mem_rdata_s;
        end
    end

    apb_mem_array #(
        .DATAW (DATAW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (mem_we_s),
        .waddr (idx_r),
        .wstrb (strb_r),
        .wdata (wdata_r),
        .raddr (idx_s),
        .rdata (mem_rdata_s)
    );

    assign PREADY  = ready_s;
    assign PRDATA  = prdata_r;
    assign PSLVERR = (ready_s && err_r) ? ERROR : OKAY;

endmodule

// File: doc/apb_mem_slave_ws.md
Name: apb_mem_slave_ws

Overview:
Parametrised APB4 memory-mapped slave: word-organised RAM with byte strobes, programmable wait states, and address/alignment error response.
Successor to the fixed-width, zero-decode APB slave. Adds PSTRB, a base-address window, PSLVERR generation and an explicit transfer FSM.
Sits behind the APB bridge as a scratch/config RAM target.

Parameters:
ADDRW, 32, PADDR width
DATAW, 32, PWDATA/PRDATA width; must be 8, 16, 32 or 64
DEPTH, 256, number of DATAW-bit words; power of two
BASE_ADDR, 0, byte base address of the window; aligned to DEPTH*DATAW/8
WAIT_CYCLES, 1, wait states inserted per transfer; 0..15
WP_WORDS, 16, read-only words from index 0; used only with the optional feature

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESETn  input  1  asynchronous active-low reset
PADDR  input  ADDRW  byte address
PSEL  input  1  slave select
PENABLE  input  1  access phase
PWRITE  input  1  1=write, 0=read
PWDATA  input  DATAW  write data
PSTRB  input  DATAW/8  byte write strobes; ignored on reads
PREADY  output  1  transfer completion
PRDATA  output  DATAW  read data
PSLVERR  output  1  error response; meaningful only while PREADY=1

Behaviour:
- Reset: asynchronous on PRESETn low; applies immediately, mid-transfer included. State=IDLE, PREADY=0, PRDATA=0, PSLVERR=0, wait counter=0, all memory words=0.
- Address decode:
  - Offset = PADDR-BASE_ADDR; word index = offset>>log2(DATAW/8).
  - err = (PADDR<BASE_ADDR) | (index>=DEPTH) | (low log2(DATAW/8) bits of PADDR nonzero).
- FSM states: IDLE, ACCESS.
- IDLE, on PSEL=1 and PENABLE=0 (setup phase), at the clock edge:
  - latch index, err, PWRITE, PWDATA, PSTRB;
  - load counter=WAIT_CYCLES;
  - read case: PRDATA <= err ? 0 : mem[index];
  - go to ACCESS.
- ACCESS:
  - PREADY = (counter==0), combinational from registered state and counter.
  - While PSEL=1, PENABLE=1 and counter!=0: decrement counter.
  - On the edge with PREADY=1 and a write without err: update bytes of mem[index] where PSTRB[b]=1. Other bytes are unchanged.
  - PSLVERR = PREADY & err_latched; 0 at all other times.
  - After completion: go to IDLE. A following setup phase (PSEL=1, PENABLE=0) is accepted in the next cycle, so back-to-back transfers carry no idle gap beyond APB protocol.
- WAIT_CYCLES=0: access phase completes in its first cycle (2-cycle APB transfer).
- PSEL deasserted in ACCESS before completion (protocol violation): abort, no memory update, return to IDLE.
- PSEL=1 and PENABLE=1 while in IDLE: ignored, stay IDLE.
- Errored write: memory unchanged.
- Errored read: PRDATA=0.
- PRDATA holds its last value outside read transfers.
- PSTRB=0 on a write: completes, no update, PSLVERR=0.

Optional Feature:
- Macro APB_MEM_WRITE_PROTECT_EN.
- Defined: words with index<WP_WORDS are read-only. A write there sets err (PSLVERR=1 at completion) and does not update memory. Reads are unaffected.
- Undefined: WP_WORDS is ignored and all in-range words are writable.

Decomposition:
- Package apb_mem_pkg holds:
  - the FSM state typedef (IDLE, ACCESS);
  - a localparam function for strobe width (DATAW/8) and byte-offset bits;
  - the PSLVERR response constants OKAY=0, ERROR=1.
- Sub-module apb_mem_array: DEPTH x DATAW storage with async-reset clear, byte-strobe write port, registered-by-caller read port. The top instantiates it once.

Test Plan:
- Write 0xDEADBEEF, PSTRB=4'hF, to 0x10 with WAIT_CYCLES=1, then read 0x10 -> PREADY high on 2nd access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD with PSTRB=4'b0101, then read -> PRDATA=0x11BB33DD.
- Read 0x402 (misaligned) and 0x400 (index 256, out of range) -> PSLVERR=1 with PREADY, PRDATA=0; a prior write to word 0 is unchanged.
- WAIT_CYCLES=0, back-to-back write then read of 0x04 -> each transfer is 2 cycles, read returns the written data.
- Assert PRESETn low during ACCESS of a write to 0x08 -> PREADY=0, PRDATA=0 immediately; word 2 reads 0 afterwards.
- APB_MEM_WRITE_PROTECT_EN, WP_WORDS=16: write 0x5 to 0x00 -> PSLVERR=1, readback 0. Write to 0x40 -> PSLVERR=0, readback 0x5.
